// File: rtl/apb_reg_arbiter.sv
// Two-requester APB master in front of a fixed five-register file.
// Round-robin grant, illegal accesses answered locally without an APB cycle.

module apb_reg_decode #(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_write,
  output logic              o_legal
);
  logic w_hit;

  always_comb begin
    w_hit = 1'b0;
    case (i_addr)
      ADDR_W'(32'h00), ADDR_W'(32'h04), ADDR_W'(32'h08),
      ADDR_W'(32'h0C), ADDR_W'(32'h10): w_hit = 1'b1;
      default:                          w_hit = 1'b0;
    endcase
  end

  // 0x04 is the read-only status register
  assign o_legal = w_hit && !(i_write && (i_addr == ADDR_W'(32'h04)));
endmodule

module apb_reg_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              m0_req,
  input  logic              m0_write,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic              m1_write,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_err,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  input  logic [DATA_W-1:0] prdata
);
  typedef enum logic [2:0] {IDLE, SETUP, ACCESS, CAPTURE, RESP} state_t;

  state_t                   r_state;
  logic                     r_last_grant;
  logic                     r_gnt_id;
  logic [ADDR_W-1:0]        r_paddr;
  logic [DATA_W-1:0]        r_pwdata;
  logic                     r_pwrite;
  logic                     r_psel;
  logic                     r_penable;
  logic [1:0]               r_ack;
  logic [1:0]               r_err;
  logic [1:0][DATA_W-1:0]   r_rdata;

  logic [1:0]               w_req;
  logic [1:0]               w_write;
  logic [1:0]               w_legal;
  logic [1:0][ADDR_W-1:0]   w_addr;
  logic [1:0][DATA_W-1:0]   w_wdata;
  logic                     w_gnt;

  assign w_req   = {m1_req, m0_req};
  assign w_write = {m1_write, m0_write};
  assign w_addr  = {m1_addr, m0_addr};
  assign w_wdata = {m1_wdata, m0_wdata};

  for (genvar g = 0; g < 2; g++) begin : g_dec
    apb_reg_decode #(.ADDR_W(ADDR_W)) u_dec (
      .i_addr  (w_addr[g]),
      .i_write (w_write[g]),
      .o_legal (w_legal[g])
    );
  end

  // Sole requester wins; on a tie the one not served last wins.
  always_comb begin
    case (w_req)
      2'b01:   w_gnt = 1'b0;
      2'b10:   w_gnt = 1'b1;
      default: w_gnt = ~r_last_grant;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
      r_gnt_id     <= 1'b0;
      r_paddr      <= '0;
      r_pwdata     <= '0;
      r_pwrite     <= 1'b0;
      r_psel       <= 1'b0;
      r_penable    <= 1'b0;
      r_ack        <= '0;
      r_err        <= '0;
      r_rdata      <= '0;
    end else begin
      r_ack <= '0;
      case (r_state)
        IDLE: begin
          if (|w_req) begin
            r_gnt_id     <= w_gnt;
            r_last_grant <= w_gnt;
            r_paddr      <= w_addr[w_gnt];
            r_pwdata     <= w_wdata[w_gnt];
            r_pwrite     <= w_write[w_gnt];
            if (w_legal[w_gnt]) begin
              r_psel  <= 1'b1;
              r_state <= SETUP;
            end else begin
              r_ack[w_gnt]   <= 1'b1;
              r_err[w_gnt]   <= 1'b1;
              r_rdata[w_gnt] <= '0;
              r_state        <= RESP;
            end
          end
        end
        SETUP: begin
          r_penable <= 1'b1;
          r_state   <= ACCESS;
        end
        ACCESS: begin
          r_psel    <= 1'b0;
          r_penable <= 1'b0;
          if (r_pwrite) begin
            r_ack[r_gnt_id]   <= 1'b1;
            r_err[r_gnt_id]   <= 1'b0;
            r_rdata[r_gnt_id] <= '0;
            r_state           <= RESP;
          end else begin
            r_state <= CAPTURE;
          end
        end
        // register file presents read data one cycle after ACCESS
        CAPTURE: begin
          r_ack[r_gnt_id]   <= 1'b1;
          r_err[r_gnt_id]   <= 1'b0;
          r_rdata[r_gnt_id] <= prdata;
          r_state           <= RESP;
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign paddr    = r_paddr;
  assign pwdata   = r_pwdata;
  assign pwrite   = r_pwrite;
  assign psel     = r_psel;
  assign penable  = r_penable;
  assign m0_ack   = r_ack[0];
  assign m1_ack   = r_ack[1];
  assign m0_err   = r_err[0];
  assign m1_err   = r_err[1];
  assign m0_rdata = r_rdata[0];
  assign m1_rdata = r_rdata[1];
endmodule

// File: doc/apb_reg_arbiter.md
# apb_reg_arbiter

Two-port APB master that shares the APB register file between two independent requesters, such as a firmware bus bridge and a DMA/sequencer engine. It arbitrates round-robin, drives the APB setup and access phases, and captures read data. It returns a one-cycle acknowledge with read data and an error flag. It sits directly in front of the register file: cntrl at 0x00 (4 bits), reg1 at 0x04 (read-only), reg2–reg4 at 0x08–0x10. That register file has no pready and presents read data registered, one cycle after ACCESS.

## Interface
- ADDR_W, 32, APB and requester address width
- DATA_W, 32, APB and requester data width
- pclk  in  1  APB clock; all logic on rising edge
- presetn  in  1  asynchronous active-low reset
- mN_req  in  1  (N=0,1) request; held high with fields stable until mN_ack
- mN_write  in  1  1 = write, 0 = read
- mN_addr  in  ADDR_W  byte address
- mN_wdata  in  DATA_W  write data
- mN_ack  out  1  one-cycle completion pulse
- mN_rdata  out  DATA_W  read data, valid while mN_ack=1
- mN_err  out  1  illegal-access flag, valid while mN_ack=1
- paddr  out  ADDR_W  APB address
- pwdata  out  DATA_W  APB write data
- psel  out  1  APB select
- penable  out  1  APB enable
- pwrite  out  1  APB direction
- prdata  in  DATA_W  APB read data from the register file

## Operation
- State machine states: IDLE, SETUP, ACCESS, CAPTURE, RESP. Reset state is IDLE.
- IDLE behaviour:
  - Samples m0_req and m1_req.
  - If either is high, it grants one and registers paddr, pwdata and pwrite from the granted requester's fields.
  - It also registers grant_id.
- Arbitration is round-robin on last_grant. Reset value of last_grant is 1, so m0 wins the first tie.
  - Only one requester high: that requester is granted.
  - Both high: the requester not equal to last_grant is granted.
  - last_grant updates at the grant edge.
- Legal access rules:
  - Legal addresses are 0x00, 0x04, 0x08, 0x0C and 0x10.
  - Legal writes exclude 0x04.
  - Illegal request path: IDLE→RESP with err=1 and rdata=0. No APB cycle is issued, and psel stays 0.
- Legal request path:
  - Write: IDLE→SETUP→ACCESS→RESP.
  - Read: IDLE→SETUP→ACCESS→CAPTURE→RESP.
- Per-state outputs:
  - SETUP: psel=1, penable=0.
  - ACCESS: psel=1, penable=1. The register file commits the write, or latches read data, at the end of ACCESS.
  - CAPTURE: psel=0, penable=0. The read-data register is loaded from prdata at the end of CAPTURE.
  - RESP: mN_ack=1 for grant_id only, mN_rdata=captured value and mN_err as decoded. For writes, rdata=0. Next state is IDLE.
- paddr, pwdata and pwrite hold their last values outside SETUP/ACCESS.
- Requester rules:
  - A requester must drop mN_req at the edge ending its ack cycle.
  - It may instead keep mN_req high with new fields to issue the next transaction.
  - The next transaction is sampled in the following IDLE cycle.
- No requests are dropped. A non-granted request waits in IDLE arbitration.

## Timing
- Reset values:
  - psel=0, penable=0, pwrite=0, paddr=0, pwdata=0.
  - mN_ack=0, mN_rdata=0, mN_err=0.
  - state=IDLE, last_grant=1.
- All outputs are registered or decoded from registered state only. There is no combinational path from mN_req or prdata to any output.
- Latency is counted from the IDLE cycle in which req is sampled (cycle 0) to the ack cycle:
  - Legal write: ack in cycle 3.
  - Legal read: ack in cycle 4.
  - Illegal access: ack in cycle 1.
- Minimum spacing from one ack to the next grant is 1 IDLE cycle. Back-to-back throughput is 4 cycles per write and 5 cycles per read.
- Both requesters high continuously: grants strictly alternate.
- A request arriving in SETUP through RESP waits. It is not sampled mid-transaction.
- Asynchronous reset mid-operation:
  - All outputs go to their reset values immediately.
  - The in-flight transaction is abandoned and no ack is issued.
  - After reset release, the next arbitration again favours m0.
- mN_rdata and mN_err are meaningful only while mN_ack=1. They hold their values otherwise.

## Test plan
- Reset, then m0 reads 0x04 → SETUP/ACCESS seen on APB, m0_ack in cycle 4, m0_rdata=0x5A5A5555, m0_err=0.
- m1 writes 0x08=0xDEADBEEF, then reads 0x08 → write ack in cycle 3 with psel/penable sequence 10→11→00; read returns 0xDEADBEEF.
- m0 writes 0x00=0xFFFFFFFF, then reads 0x00 → rdata=0x0000000F.
- Both requesters hold reads of 0x0C continuously for 6 transactions → grants m0,m1,m0,m1,m0,m1; each gets 0xA5A50000; no ack overlap.
- Illegal accesses:
  - m0 writes 0x04 → ack in cycle 1, err=1, psel never asserted.
  - m1 reads 0x14 → err=1, rdata=0.
- Reset asserted during ACCESS of an m0 write to 0x10 → psel=0 and penable=0 immediately; no m0_ack; reset-to-IDLE behaviour as specified.
